// File: rtl/systolic_pkg.sv
// Shared encodings for the 2x2 systolic feeder: FSM states, matrix
// element addresses and array geometry.
package systolic_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] FLOW = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_FILL = FILL,
      S_FLOW = FLOW,
      S_HOLD = HOLD
   } state_e;

   localparam logic [2:0] ADDR_A00 = 3'd0;
   localparam logic [2:0] ADDR_A01 = 3'd1;
   localparam logic [2:0] ADDR_A10 = 3'd2;
   localparam logic [2:0] ADDR_A11 = 3'd3;
   localparam logic [2:0] ADDR_B00 = 3'd4;
   localparam logic [2:0] ADDR_B01 = 3'd5;
   localparam logic [2:0] ADDR_B10 = 3'd6;
   localparam logic [2:0] ADDR_B11 = 3'd7;

   localparam int FILL_CYCLES = 8;
   localparam int ARRAY_N     = 2;

endpackage

// File: rtl/skew_mux_2x2.sv
// Combinational skew map: push index plus A/B elements -> the four
// operand stream values loaded into the array's input buffers.
module skew_mux_2x2 #(
   parameter int WIDTH = 16
) (
   input  logic [1:0]       push_i,
   input  logic [WIDTH-1:0] a00_i,
   input  logic [WIDTH-1:0] a01_i,
   input  logic [WIDTH-1:0] a10_i,
   input  logic [WIDTH-1:0] a11_i,
   input  logic [WIDTH-1:0] b00_i,
   input  logic [WIDTH-1:0] b01_i,
   input  logic [WIDTH-1:0] b10_i,
   input  logic [WIDTH-1:0] b11_i,
   output logic [WIDTH-1:0] west0_o,
   output logic [WIDTH-1:0] west1_o,
   output logic [WIDTH-1:0] north0_o,
   output logic [WIDTH-1:0] north1_o
);

   always_comb begin
      west0_o  = '0;
      west1_o  = '0;
      north0_o = '0;
      north1_o = '0;
      case (push_i)
         2'd0: begin
            west0_o  = a00_i;
            north0_o = b00_i;
         end
         2'd1: begin
            west0_o  = a01_i;
            west1_o  = a10_i;
            north0_o = b10_i;
            north1_o = b01_i;
         end
         2'd2: begin
            west1_o  = a11_i;
            north1_o = b11_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Sequencer feeding the 2x2 systolic array and collecting its results.
// Define SYSTOLIC_FEEDER_RELU_EN to clamp negative results to zero on capture.
//
// state | meaning
// IDLE  | array held in reset, matrix writes and go accepted
// FILL  | 8 cycles, four fill pulses loading skewed operands
// FLOW  | array running, waiting for done_in or timeout
// HOLD  | results presented until consumer takes them
module systolic_feeder_2x2
   import systolic_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             go,
   output logic             busy,
   output logic             err,
   output logic [7:0]       shift_n_flow,
   output logic [7:0]       start,
   output logic [7:0]       array_reset,
   output logic [WIDTH-1:0] inp_west0_buf,
   output logic [WIDTH-1:0] inp_west1_buf,
   output logic [WIDTH-1:0] inp_north0_buf,
   output logic [WIDTH-1:0] inp_north1_buf,
   input  logic             done_in,
   input  logic [WIDTH-1:0] result0_in,
   input  logic [WIDTH-1:0] result1_in,
   input  logic [WIDTH-1:0] result2_in,
   input  logic [WIDTH-1:0] result3_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c00,
   output logic [WIDTH-1:0] c01,
   output logic [WIDTH-1:0] c10,
   output logic [WIDTH-1:0] c11
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam int NUM_C = ARRAY_N * ARRAY_N;
   localparam int NUM_M = 2 * NUM_C;

   state_e           state_q, state_d;
   logic [2:0]       fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mat_q [NUM_M];
   logic [WIDTH-1:0] mat_d [NUM_M];
   logic [WIDTH-1:0] res_q [NUM_C];
   logic [WIDTH-1:0] res_d [NUM_C];
   logic [WIDTH-1:0] res_in [NUM_C];
   logic             err_q, err_d, valid_q, valid_d, busy_q, busy_d;
   logic [7:0]       sfl_q, sfl_d, start_q, start_d, arst_q, arst_d;
   logic [WIDTH-1:0] w0_q, w1_q, n0_q, n1_q, w0_d, w1_d, n0_d, n1_d;
   logic [WIDTH-1:0] mux_w0, mux_w1, mux_n0, mux_n1;

   assign res_in[0] = result0_in;
   assign res_in[1] = result1_in;
   assign res_in[2] = result2_in;
   assign res_in[3] = result3_in;

`ifdef SYSTOLIC_FEEDER_RELU_EN
   function automatic logic [WIDTH-1:0] capture(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? '0 : v;
   endfunction
`else
   function automatic logic [WIDTH-1:0] capture(input logic [WIDTH-1:0] v);
      return v;
   endfunction
`endif

   // Fed from next-state values so a same-edge write is already visible in push 0.
   skew_mux_2x2 #(.WIDTH(WIDTH)) u_skew (
      .push_i   (fill_d[2:1]),
      .a00_i    (mat_d[ADDR_A00]),
      .a01_i    (mat_d[ADDR_A01]),
      .a10_i    (mat_d[ADDR_A10]),
      .a11_i    (mat_d[ADDR_A11]),
      .b00_i    (mat_d[ADDR_B00]),
      .b01_i    (mat_d[ADDR_B01]),
      .b10_i    (mat_d[ADDR_B10]),
      .b11_i    (mat_d[ADDR_B11]),
      .west0_o  (mux_w0),
      .west1_o  (mux_w1),
      .north0_o (mux_n0),
      .north1_o (mux_n1)
   );

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      mat_d   = mat_q;
      res_d   = res_q;
      err_d   = err_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (wr_en) mat_d[wr_addr] = wr_data;
            if (go) begin
               state_d = S_FILL;
               fill_d  = '0;
               err_d   = 1'b0;
            end
         end
         S_FILL: begin
            fill_d = fill_q + 3'd1;
            if (fill_q == 3'(FILL_CYCLES - 1)) begin
               state_d = S_FLOW;
               cnt_d   = '0;
            end
         end
         S_FLOW: begin
            if (done_in) begin
               for (int i = 0; i < NUM_C; i++) res_d[i] = capture(res_in[i]);
               valid_d = 1'b1;
               state_d = S_HOLD;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered outputs are decoded from the state being entered.
      busy_d  = (state_d != S_IDLE);
      arst_d  = (state_d == S_IDLE) ? 8'hFF : 8'h00;
      start_d = (state_d == S_FLOW) ? 8'hFF : 8'h00;
      sfl_d   = 8'h00;
      if (state_d == S_FILL) sfl_d = fill_d[0] ? 8'h00 : 8'h0F;
      else if (state_d == S_FLOW) sfl_d = 8'hF0;
      w0_d = (state_d == S_FILL) ? mux_w0 : '0;
      w1_d = (state_d == S_FILL) ? mux_w1 : '0;
      n0_d = (state_d == S_FILL) ? mux_n0 : '0;
      n1_d = (state_d == S_FILL) ? mux_n1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         fill_q  <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < NUM_M; i++) mat_q[i] <= '0;
         for (int i = 0; i < NUM_C; i++) res_q[i] <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         sfl_q   <= 8'h00;
         start_q <= 8'h00;
         arst_q  <= 8'hFF;
         w0_q    <= '0;
         w1_q    <= '0;
         n0_q    <= '0;
         n1_q    <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         mat_q   <= mat_d;
         res_q   <= res_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         sfl_q   <= sfl_d;
         start_q <= start_d;
         arst_q  <= arst_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         n0_q    <= n0_d;
         n1_q    <= n1_d;
      end
   end

   assign busy           = busy_q;
   assign err            = err_q;
   assign shift_n_flow   = sfl_q;
   assign start          = start_q;
   assign array_reset    = arst_q;
   assign inp_west0_buf  = w0_q;
   assign inp_west1_buf  = w1_q;
   assign inp_north0_buf = n0_q;
   assign inp_north1_buf = n1_q;
   assign out_valid      = valid_q;
   assign c00            = res_q[0];
   assign c01            = res_q[1];
   assign c10            = res_q[2];
   assign c11            = res_q[3];

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2 with a behavioural 2x2 array model that
// rebuilds A and B from the fill pulses and answers 7 cycles after start.
module tb_systolic_feeder_2x2;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_en = 1'b0;
   logic [2:0]   wr_addr = '0;
   logic [W-1:0] wr_data = '0;
   logic         go = 1'b0;
   logic         busy, err, out_valid;
   logic         out_ready = 1'b1;
   logic [7:0]   shift_n_flow, start, array_reset;
   logic [W-1:0] inp_west0_buf, inp_west1_buf, inp_north0_buf, inp_north1_buf;
   logic         done_in = 1'b0;
   logic [W-1:0] result0_in = '0, result1_in = '0, result2_in = '0, result3_in = '0;
   logic [W-1:0] c00, c01, c10, c11;

   int n_checks = 0;
   int n_fail   = 0;
   logic [4*W-1:0] exp_q [$];

   always #5 clk = ~clk;

   systolic_feeder_2x2 #(.WIDTH(W), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .go(go), .busy(busy), .err(err), .shift_n_flow(shift_n_flow), .start(start),
      .array_reset(array_reset), .inp_west0_buf(inp_west0_buf), .inp_west1_buf(inp_west1_buf),
      .inp_north0_buf(inp_north0_buf), .inp_north1_buf(inp_north1_buf), .done_in(done_in),
      .result0_in(result0_in), .result1_in(result1_in), .result2_in(result2_in),
      .result3_in(result3_in), .out_valid(out_valid), .out_ready(out_ready),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Array model
   logic         model_en = 1'b1;
   logic [W-1:0] w0 [4], w1 [4], n0 [4], n1 [4];
   logic [3:0]   prev_fill = 4'h0;
   int           pcnt = 0;
   int           scnt = 0;

   initial for (int i = 0; i < 4; i++) begin
      w0[i] = '0; w1[i] = '0; n0[i] = '0; n1[i] = '0;
   end

   always @(negedge clk) begin
      if (array_reset == 8'hFF) pcnt = 0;
      else if (shift_n_flow[3:0] == 4'hF && prev_fill == 4'h0 && pcnt < 4) begin
         w0[pcnt] = inp_west0_buf;
         w1[pcnt] = inp_west1_buf;
         n0[pcnt] = inp_north0_buf;
         n1[pcnt] = inp_north1_buf;
         pcnt++;
      end
      prev_fill = shift_n_flow[3:0];
      if (start == 8'hFF && model_en) scnt++;
      else scnt = 0;
      done_in    = (scnt >= 8);
      result0_in = w0[0] * n0[0] + w0[1] * n0[1];
      result1_in = w0[0] * n1[1] + w0[1] * n1[2];
      result2_in = w1[1] * n0[0] + w1[2] * n0[1];
      result3_in = w1[1] * n1[1] + w1[2] * n1[2];
   end

   // Scoreboard monitor: one transfer per valid&ready cycle
   always @(negedge clk) begin
      if (rst_n && out_valid === 1'b1 && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h, expected none", {c00, c01, c10, c11});
         end else begin
            logic [4*W-1:0] e;
            e = exp_q.pop_front();
            chk("c00", 64'(c00), 64'(e[63:48]));
            chk("c01", 64'(c01), 64'(e[47:32]));
            chk("c10", 64'(c10), 64'(e[31:16]));
            chk("c11", 64'(c11), 64'(e[15:0]));
         end
      end
   end

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] a00, a01, a10, a11, b00, b01, b10, b11);
      wr(3'd0, a00); wr(3'd1, a01); wr(3'd2, a10); wr(3'd3, a11);
      wr(3'd4, b00); wr(3'd5, b01); wr(3'd6, b10); wr(3'd7, b11);
   endtask

   // go pulse, then wait (bounded) for out_valid; returns cycles from go edge
   task automatic run_mult(input bit wr_flow, output int lat, output logic [31:0] fill_hist,
                           output logic err_after_go);
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      err_after_go = err;
      fill_hist = {shift_n_flow[3:0], 28'h0};
      lat = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         if (cyc < 8) fill_hist[31 - 4*cyc -: 4] = shift_n_flow[3:0];
         if (wr_flow && cyc == 10) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd99;
         end
         if (cyc == 11) wr_en = 1'b0;
         if (out_valid) begin
            lat = cyc;
            break;
         end
      end
      if (lat == 0) chk("out_valid_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      int           lat, rises, tcyc;
      logic [31:0]  hist;
      logic         e_go, seen_valid;
      logic [63:0]  res1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_array_reset", 64'(array_reset), 64'hFF);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_shift_start", 64'({shift_n_flow, start}), 64'h0);
      chk("rst_c", 64'({c00, c01, c10, c11}), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic multiply with backpressure and a write attempted during FLOW
      load(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
      res1 = {16'd19, 16'd22, 16'd43, 16'd50};
      exp_q.push_back(res1);
      out_ready = 1'b0;
      run_mult(1'b1, lat, hist, e_go);
      chk("latency_basic", 64'(lat), 64'd16);
      chk("fill_pattern", 64'(hist), 64'hF0F0F0F0);
      rises = 0;
      for (int i = 0; i < 8; i++) begin
         logic [3:0] cur, prv;
         cur = hist[31 - 4*i -: 4];
         prv = (i == 0) ? 4'h0 : hist[35 - 4*i -: 4];
         if (cur == 4'hF && prv == 4'h0) rises++;
      end
      chk("fill_pulses", 64'(rises), 64'd4);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         go = (i == 3);
         chk("hold_c_stable", {c00, c01, c10, c11}, res1);
         chk("hold_busy_valid", 64'({busy, out_valid}), 64'h3);
      end
      go = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid_busy", 64'({out_valid, busy}), 64'h0);
      chk("release_array_reset", 64'(array_reset), 64'hFF);
      @(posedge clk); #1;
      chk("go_not_queued", 64'(busy), 64'h0);

      // Second go with no rewrite: 99 must not have been stored
      exp_q.push_back(res1);
      run_mult(1'b0, lat, hist, e_go);
      chk("latency_second", 64'(lat), 64'd16);
      repeat (2) @(posedge clk); #1;

      // Timeout with done_in held low
      model_en = 1'b0;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      tcyc = 0;
      seen_valid = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         if (out_valid) seen_valid = 1'b1;
         if (!busy) begin
            tcyc = cyc;
            break;
         end
      end
      chk("timeout_cycles", 64'(tcyc), 64'd24);
      chk("timeout_err", 64'(err), 64'h1);
      chk("timeout_array_reset", 64'(array_reset), 64'hFF);
      chk("timeout_no_valid", 64'(seen_valid), 64'h0);
      model_en = 1'b1;
      exp_q.push_back(res1);
      run_mult(1'b0, lat, hist, e_go);
      chk("err_cleared_by_go", 64'(e_go), 64'h0);
      repeat (2) @(posedge clk); #1;

      // Async reset during FILL cycle 3
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_array_reset", 64'(array_reset), 64'hFF);
      chk("areset_shift", 64'(shift_n_flow), 64'h0);
      chk("areset_busy", 64'(busy), 64'h0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(64'h0);
      run_mult(1'b0, lat, hist, e_go);
      chk("latency_after_reset", 64'(lat), 64'd16);
      repeat (2) @(posedge clk); #1;

      // Negative result: clamped only when the ReLU build is selected
      load(16'hFFFF, 16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd1);
`ifdef SYSTOLIC_FEEDER_RELU_EN
      exp_q.push_back({16'h0000, 16'h0000, 16'h0000, 16'h0001});
`else
      exp_q.push_back({16'hFFFF, 16'h0000, 16'h0000, 16'h0001});
`endif
      run_mult(1'b0, lat, hist, e_go);
      repeat (3) @(posedge clk); #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit, expected test completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/systolic_feeder_2x2.md
Name: systolic_feeder_2x2

Overview:
- Upstream sequencer for the 2x2 systolic array.
- Accepts matrices A and B (2x2 each) through a simple write port.
- Drives the array's four buffer inputs with skewed operand streams, and drives its shift_n_flow, start and reset vectors.
- Waits for the array's done, captures the four results and presents them on a valid/ready output port.

Parameters:
- WIDTH, 16, operand/result width; must match the array.
- TIMEOUT, 16, maximum FLOW cycles to wait for done_in before aborting.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  matrix element write strobe.
- wr_addr  in  3  0-3 = A00,A01,A10,A11; 4-7 = B00,B01,B10,B11.
- wr_data  in  WIDTH  element value.
- go  in  1  start one multiply.
- busy  out  1  high outside IDLE.
- err  out  1  sticky timeout flag, cleared by the next accepted go.
- shift_n_flow  out  8  to array; [3:0] fill, [7:4] flow.
- start  out  8  to array.
- array_reset  out  8  to array, active-high.
- inp_west0_buf, inp_west1_buf, inp_north0_buf, inp_north1_buf  out  WIDTH each  operand streams to the array.
- done_in  in  1  array done.
- result0_in..result3_in  in  WIDTH each  array results.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- c00, c01, c10, c11  out  WIDTH each  captured results.

Behaviour:
- All outputs are registered.
- Reset values:
  - array_reset = 8'hFF.
  - All other outputs 0, including busy, err, out_valid and c*.
  - Matrix registers 0; state IDLE.
- States: IDLE, FILL, FLOW, HOLD.
- IDLE:
  - array_reset = 8'hFF, shift_n_flow = 0, start = 0.
  - wr_en writes the addressed element. Writes in any other state are ignored.
  - go moves to FILL next edge.
  - wr_en and go on the same edge: the write lands, and the new value is used.
- FILL: 8 cycles, push index p = 0..3, two cycles per push.
  - array_reset = 0.
  - Cycle 2p: drive the push-p data and shift_n_flow[3:0] = 4'hF.
  - Cycle 2p+1: shift_n_flow = 0, data held. The low cycle is needed because the buffers shift only on the rising edge of fill.
  - Push sequences, p = 0..3:
    - west0: A00, A01, 0, 0.
    - west1: 0, A10, A11, 0.
    - north0: B00, B10, 0, 0.
    - north1: 0, B01, B11, 0.
  - After the last push, enter FLOW.
- FLOW:
  - shift_n_flow = 8'hF0, start = 8'hFF, all data outputs 0.
  - A cycle counter starts at 0.
  - done_in = 1: capture result0..3_in into c00, c01, c10, c11, drop start and flow to 0, set out_valid, go to HOLD. This happens on the same edge.
  - Counter reaches TIMEOUT without done_in: set err, array_reset = 8'hFF, go to IDLE with out_valid left 0.
- HOLD:
  - shift_n_flow = 0, start = 0, array_reset = 0.
  - c* stay stable while out_valid = 1.
  - out_valid & out_ready: clear out_valid and go to IDLE; array_reset = 8'hFF from that edge.
- go outside IDLE is ignored; it is neither queued nor an error.
- Asynchronous rst_n assertion at any point returns immediately to reset values. Any in-progress result is lost. array_reset reasserts to 8'hFF asynchronously.
- Latency: go edge → first FILL cycle is 1; FILL is 8; FLOW lasts until done_in. With the current array, done_in comes 7 cycles after start, so go → out_valid is 16 cycles.
- Width rule: c* = captured value, no truncation or extension.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_RELU_EN.
- Defined: on capture, each result is treated as signed two's complement. Any value with MSB = 1 is replaced by 0; others pass unchanged.
- Undefined: results are captured unmodified. No extra logic.

Decomposition:
- Shared package systolic_pkg holds:
  - State encoding localparams: IDLE = 2'd0, FILL = 2'd1, FLOW = 2'd2, HOLD = 2'd3.
  - Address constants for A/B elements.
  - FILL_CYCLES = 8 and ARRAY_N = 2.
- One natural sub-module: skew_mux_2x2. It is combinational: it maps push index plus the A/B registers to the four stream values. The FSM and counters stay in the top.

Test Plan:
- Basic multiply:
  - Stimulus: write A = [[1,2],[3,4]], B = [[5,6],[7,8]]; go, with the real array attached.
  - Required: out_valid 16 cycles after go; c00 = 19, c01 = 22, c10 = 43, c11 = 50.
  - Required during FILL: shift_n_flow alternates 4'hF/0 exactly 4 times.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid.
  - Required: c* stable, busy = 1, go ignored; on out_ready = 1, out_valid drops next edge and state returns to IDLE.
- Write gating:
  - Stimulus: wr_en to A00 = 99 during FLOW, then a second go with no rewrite.
  - Required: second result identical to the first (99 not stored).
- Timeout:
  - Stimulus: array model with done_in tied 0.
  - Required: after 16 FLOW cycles err = 1, busy = 0, array_reset = 8'hFF, out_valid never set; the next go clears err.
- Async reset mid-FILL:
  - Stimulus: rst_n low at FILL cycle 3.
  - Required: the same cycle sees array_reset = 8'hFF, shift_n_flow = 0 and busy = 0; the matrix registers read 0 on the next run.
- RELU (SYSTOLIC_FEEDER_RELU_EN defined, WIDTH = 16):
  - Stimulus: A = [[-1,0],[0,1]], B = identity.
  - Required: c00 = 0, c11 = 1.
  - Without the macro: c00 = 16'hFFFF.
